tree_traverser: RTL

- Inference engine for one decision tree; sits directly downstream of the per-tree node ROMs.
- Accepts a 16-entry IEEE-754 double feature vector, then walks the tree from ROOT_ADDR:
  - drives the ROM address;
  - consumes the registered 120-bit node word returned one cycle later;
  - compares the selected feature against the node threshold and follows the left or right child until it reaches a leaf.
- Reports the leaf class and depth to the ensemble voter through a valid/ready handshake.

---
 rtl/tree_traverser.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/tree_traverser.sv
`default_nettype none
// ============================================================================
// Module      : tree_traverser
// Description : Walks one decision tree held in an external registered node
//               ROM. Latches a feature vector, fetches nodes from the root,
//               compares the selected IEEE-754 double feature against each
//               node threshold and follows the left/right child until a leaf
//               is reached. Returns the leaf class and traversal depth (or an
//               abort flag) through a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tree_traverser #(
  parameter int NODE_WIDTH   = 120,
  parameter int ADDR_WIDTH   = 10,
  parameter int ROM_DEPTH    = 512,
  parameter int NUM_FEATURES = 16,
  parameter int FEAT_WIDTH   = 64,
  parameter int MAX_DEPTH    = 32,
  parameter int ROOT_ADDR    = 0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  // feature vector input
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [NUM_FEATURES*FEAT_WIDTH-1:0] features,
  // node ROM interface (ROM output is registered)
  output logic [ADDR_WIDTH-1:0]              rom_addr,
  input  logic [NODE_WIDTH-1:0]              rom_data,
  // result output
  output logic                               res_valid,
  input  logic                               res_ready,
  output logic                               res_class,
  output logic [5:0]                         res_depth,
  output logic                               res_error
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EVAL  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [3:0]            TYPE_INTERNAL = 4'h3;
  localparam logic [ADDR_WIDTH-1:0] ROOT          = ADDR_WIDTH'(ROOT_ADDR);
  localparam logic [5:0]            DEPTH_LIMIT   = 6'(MAX_DEPTH);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]                         state_q,     state_d;
  logic [NUM_FEATURES*FEAT_WIDTH-1:0] feat_q,      feat_d;
  logic [5:0]                         depth_q,     depth_d;
  logic [ADDR_WIDTH-1:0]              rom_addr_q,  rom_addr_d;
  logic                               res_valid_q, res_valid_d;
  logic                               res_class_q, res_class_d;
  logic [5:0]                         res_depth_q, res_depth_d;
  logic                               res_error_q, res_error_d;

  // --------------------------------------------------------------------------
  // Node word fields
  // --------------------------------------------------------------------------
  logic [3:0]  node_fidx;
  logic [63:0] node_thresh;
  logic [11:0] node_left;
  logic [11:0] node_right;
  logic [3:0]  node_type;
  logic        node_is_leaf;

  // Node id and the bits above it carry no information for traversal.
  logic unused_node_bits;
  assign unused_node_bits = ^rom_data[NODE_WIDTH-1:96];

  // Slice the registered ROM word into its fields.
  always_comb begin
    node_fidx    = rom_data[95:92];
    node_thresh  = rom_data[91:28];
    node_left    = rom_data[27:16];
    node_right   = rom_data[15:4];
    node_type    = rom_data[3:0];
    node_is_leaf = (node_type != TYPE_INTERNAL);
  end

  // --------------------------------------------------------------------------
  // IEEE-754 double "a <= b" without a floating-point unit.
  // NaN on either side is unordered and therefore goes right; +0/-0 are
  // equal; otherwise sign-magnitude ordering is resolved on the raw bits,
  // which also orders infinities and subnormals correctly.
  // --------------------------------------------------------------------------
  function automatic logic le_double(input logic [63:0] a, input logic [63:0] b);
    logic a_nan;
    logic b_nan;
    logic result;
    a_nan = (&a[62:52]) && (|a[51:0]);
    b_nan = (&b[62:52]) && (|b[51:0]);
    if (a_nan || b_nan) begin
      result = 1'b0;
    end else if ((a[62:0] == 63'd0) && (b[62:0] == 63'd0)) begin
      result = 1'b1;
    end else if (a[63] != b[63]) begin
      result = a[63];
    end else if (!a[63]) begin
      result = (a[62:0] <= b[62:0]);
    end else begin
      result = (a[62:0] >= b[62:0]);
    end
    return result;
  endfunction

  // --------------------------------------------------------------------------
  // Feature select, compare and child choice for the node under evaluation
  // --------------------------------------------------------------------------
  logic [FEAT_WIDTH-1:0] sel_feat;
  logic                  go_left;
  logic [11:0]           child;
  logic                  child_bad;
  logic                  depth_exhausted;

  // Select the indexed feature; an index with no matching slot falls back to feature 0.
  always_comb begin
    sel_feat = feat_q[FEAT_WIDTH-1:0];
    for (int i = 0; i < NUM_FEATURES; i++) begin
      if (node_fidx == 4'(i)) begin
        sel_feat = feat_q[i*FEAT_WIDTH +: FEAT_WIDTH];
      end
    end
  end

  // Decide the branch direction and whether following it would abort the walk.
  always_comb begin
    go_left         = le_double(sel_feat, node_thresh);
    child           = go_left ? node_left : node_right;
    child_bad       = (32'(child) >= 32'(ROM_DEPTH));
    depth_exhausted = (depth_q == DEPTH_LIMIT);
  end

  // --------------------------------------------------------------------------
  // Control FSM and datapath next-state
  // --------------------------------------------------------------------------
  // Compute next state of the controller, feature latch, address and result.
  always_comb begin
    state_d     = state_q;
    feat_d      = feat_q;
    depth_d     = depth_q;
    rom_addr_d  = rom_addr_q;
    res_valid_d = res_valid_q;
    res_class_d = res_class_q;
    res_depth_d = res_depth_q;
    res_error_d = res_error_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          feat_d     = features;
          depth_d    = 6'd0;
          rom_addr_d = ROOT;
          state_d    = S_FETCH;
        end
      end

      // ROM samples rom_addr on this edge; data is usable in EVAL.
      S_FETCH: begin
        state_d = S_EVAL;
      end

      S_EVAL: begin
        if (node_is_leaf) begin
          res_class_d = node_type[0];
          res_depth_d = depth_q;
          res_error_d = 1'b0;
          res_valid_d = 1'b1;
          state_d     = S_DONE;
        end else if (child_bad || depth_exhausted) begin
          res_class_d = 1'b0;
          res_depth_d = depth_q;
          res_error_d = 1'b1;
          res_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          rom_addr_d = child[ADDR_WIDTH-1:0];
          depth_d    = depth_q + 6'd1;
          state_d    = S_FETCH;
        end
      end

      S_DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Register all state; reset abandons any traversal in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      feat_q      <= '0;
      depth_q     <= 6'd0;
      rom_addr_q  <= ROOT;
      res_valid_q <= 1'b0;
      res_class_q <= 1'b0;
      res_depth_q <= 6'd0;
      res_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      feat_q      <= feat_d;
      depth_q     <= depth_d;
      rom_addr_q  <= rom_addr_d;
      res_valid_q <= res_valid_d;
      res_class_q <= res_class_d;
      res_depth_q <= res_depth_d;
      res_error_q <= res_error_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign in_ready  = (state_q == S_IDLE);
  assign rom_addr  = rom_addr_q;
  assign res_valid = res_valid_q;
  assign res_class = res_class_q;
  assign res_depth = res_depth_q;
  assign res_error = res_error_q;

endmodule
`default_nettype wire
